// File: rtl/lsu_ctrl.sv
// Load/store sequencer: issues one handshaked bus transaction per load/store,
// stalls the core while it is outstanding and returns extended load data.
module lsu_ctrl #(
  parameter int AW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mem_rd,
  input  logic          mem_wr,
  input  logic [2:0]    mask,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic          stall,
  output logic [31:0]   rdata,
  output logic          lsu_err,
  output logic          bus_req,
  output logic          bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [3:0]    bus_be,
  output logic [31:0]   bus_wdata,
  input  logic          bus_ack,
  input  logic [31:0]   bus_rdata
);

  // Bus handshake: bus_req stays high with all bus_* outputs frozen until the
  // cycle in which bus_ack is sampled high (or the wait budget runs out).
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt;
  logic [1:0]    lane_q;
  logic [2:0]    mask_q;
  logic          access, is_store, fault, issue;
  logic [3:0]    be_next;
  logic [31:0]   wdata_next, shifted, extracted;

  assign access   = mem_rd | mem_wr;
  assign is_store = mem_wr;

  always_comb begin
    fault = (mask == 3'b011) || (mask == 3'b110) || (mask == 3'b111) ||
            ((mask[1:0] == 2'b01) && addr[0]) ||
            ((mask[1:0] == 2'b10) && (addr[1:0] != 2'b00)) ||
            (is_store && mask[2]);
  end

  // Loads use the same lane pattern as a store of equal width.
  always_comb begin
    be_next    = 4'b1111;
    wdata_next = wdata;
    case (mask[1:0])
      2'b00: begin
        be_next    = 4'b0001 << addr[1:0];
        wdata_next = {4{wdata[7:0]}};
      end
      2'b01: begin
        be_next    = 4'b0011 << {addr[1], 1'b0};
        wdata_next = {2{wdata[15:0]}};
      end
      default: begin
        be_next    = 4'b1111;
        wdata_next = wdata;
      end
    endcase
  end

  always_comb begin
    shifted   = bus_rdata >> {lane_q, 3'b000};
    extracted = shifted;
    case (mask_q)
      3'b000:  extracted = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  extracted = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  extracted = {24'h0, shifted[7:0]};
      3'b101:  extracted = {16'h0, shifted[15:0]};
      default: extracted = shifted;
    endcase
  end

  always_comb begin
    state_next = state;
    stall      = 1'b0;
    bus_req    = 1'b0;
    lsu_err    = 1'b0;
    issue      = 1'b0;
    case (state)
      IDLE: begin
        if (access) begin
          if (fault) begin
            lsu_err = 1'b1;
          end else begin
            issue      = 1'b1;
            stall      = 1'b1;
            state_next = REQ;
          end
        end
      end
      REQ: begin
        stall   = 1'b1;
        bus_req = 1'b1;
        if (bus_ack) begin
          state_next = DONE;
        end else if ((TIMEOUT != 0) && (cnt == CNT_LAST)) begin
          lsu_err    = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= 4'b0000;
      bus_wdata <= 32'h0;
      rdata     <= 32'h0;
      lane_q    <= 2'b00;
      mask_q    <= 3'b000;
    end else begin
      state <= state_next;
      if (issue) begin
        bus_addr  <= {addr[AW-1:2], 2'b00};
        bus_we    <= is_store;
        bus_be    <= be_next;
        bus_wdata <= wdata_next;
        lane_q    <= addr[1:0];
        mask_q    <= mask;
        cnt       <= '0;
      end
      if (state == REQ) begin
        if (bus_ack) begin
          if (!bus_we) rdata <= extracted;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: loads, stores, wait states, faults, timeout
// (on a second instance with a short wait budget) and mid-transaction reset.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_rd = 1'b0, mem_wr = 1'b0;
  logic [2:0]  mask = 3'b000;
  logic [31:0] addr = 32'h0, wdata = 32'h0;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = 32'h0;
  logic        stall, lsu_err, bus_req, bus_we;
  logic [31:0] rdata, bus_addr, bus_wdata;
  logic [3:0]  bus_be;

  logic        mem_rd_t = 1'b0, mem_wr_t = 1'b0, ack_t = 1'b0;
  logic        stall_t, lsu_err_t, bus_req_t, bus_we_t;
  logic [31:0] rdata_t, bus_addr_t, bus_wdata_t;
  logic [3:0]  bus_be_t;

  lsu_ctrl #(.AW(32), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst), .mem_rd(mem_rd), .mem_wr(mem_wr), .mask(mask),
    .addr(addr), .wdata(wdata), .stall(stall), .rdata(rdata),
    .lsu_err(lsu_err), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  lsu_ctrl #(.AW(32), .TIMEOUT(4)) dut_to (
    .clk(clk), .rst(rst), .mem_rd(mem_rd_t), .mem_wr(mem_wr_t), .mask(mask),
    .addr(addr), .wdata(wdata), .stall(stall_t), .rdata(rdata_t),
    .lsu_err(lsu_err_t), .bus_req(bus_req_t), .bus_we(bus_we_t),
    .bus_addr(bus_addr_t), .bus_be(bus_be_t), .bus_wdata(bus_wdata_t),
    .bus_ack(ack_t), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_rdata = 32'h0;

  int          stall_cnt, req_cnt, err_cnt;
  logic        done_seen, held;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;
  logic        cap_we;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input bit is_load, input logic [31:0] val);
    if (is_load) model_rdata = val;
    exp_q.push_back(model_rdata);
  endtask

  // Drives one access, acks after `delay` wait cycles, compares rdata in DONE.
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] m,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] word, input int delay);
    mem_rd = rd; mem_wr = wr; mask = m; addr = a; wdata = wd; bus_rdata = word;
    stall_cnt = 0; req_cnt = 0; err_cnt = 0; done_seen = 1'b0; held = 1'b1;
    for (int n = 0; n < 40 && !done_seen; n++) begin
      @(negedge clk);
      if (stall) stall_cnt++;
      if (lsu_err) err_cnt++;
      if (bus_req) begin
        if (req_cnt == 0) begin
          cap_addr = bus_addr; cap_be = bus_be; cap_we = bus_we; cap_wdata = bus_wdata;
        end else if (bus_addr !== cap_addr || bus_be !== cap_be ||
                     bus_we !== cap_we || bus_wdata !== cap_wdata) begin
          held = 1'b0;
        end
        bus_ack = (req_cnt == delay);
        req_cnt++;
      end else if (req_cnt > 0) begin
        done_seen = 1'b1;
        check("rdata_done", rdata, exp_q.pop_front());
      end
      @(posedge clk); #1;
      bus_ack = 1'b0;
    end
    mem_rd = 1'b0; mem_wr = 1'b0;
    check("done_reached", 32'(done_seen), 32'd1);
    check("bus_held", 32'(held), 32'd1);
    check("no_err", 32'(err_cnt), 32'd0);
  endtask

  task automatic run_fault(input string tag, input logic rd, input logic wr,
                           input logic [2:0] m, input logic [31:0] a);
    mem_rd = rd; mem_wr = wr; mask = m; addr = a;
    @(negedge clk);
    check({tag, "_err"}, 32'(lsu_err), 32'd1);
    check({tag, "_stall"}, 32'(stall), 32'd0);
    check({tag, "_req"}, 32'(bus_req), 32'd0);
    @(posedge clk); #1;
    mem_rd = 1'b0; mem_wr = 1'b0;
    @(negedge clk);
    check({tag, "_err_gone"}, 32'(lsu_err), 32'd0);
    check({tag, "_req_idle"}, 32'(bus_req), 32'd0);
    check({tag, "_rdata"}, rdata, model_rdata);
    @(posedge clk); #1;
  endtask

  initial begin
    int lane, dly, treq, terr, tstall;
    logic [31:0] word;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req", 32'(bus_req), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_err", 32'(lsu_err), 32'd0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_addr", bus_addr, 32'h0);
    check("rst_be", 32'(bus_be), 32'h0);
    check("rst_wdata", bus_wdata, 32'h0);
    check("rst_we", 32'(bus_we), 32'd0);
    check("rst_req_t", 32'(bus_req_t), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // LB / LBU from the top byte lane
    push_exp(1, 32'hFFFF_FF80);
    run_access(1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF_1234, 0);
    check("lb_addr", cap_addr, 32'h100);
    check("lb_be", 32'(cap_be), 32'(4'b1000));
    check("lb_we", 32'(cap_we), 32'd0);
    check("lb_stall", 32'(stall_cnt), 32'd2);
    push_exp(1, 32'h0000_0080);
    run_access(1, 0, 3'b100, 32'h103, 32'h0, 32'h80FF_1234, 0);
    check("lbu_stall", 32'(stall_cnt), 32'd2);

    // Halfword loads
    push_exp(1, 32'hFFFF_80FF);
    run_access(1, 0, 3'b001, 32'h102, 32'h0, 32'h80FF_1234, 1);
    check("lh_be", 32'(cap_be), 32'(4'b1100));
    push_exp(1, 32'h0000_8001);
    run_access(1, 0, 3'b101, 32'h106, 32'h0, 32'h8001_0000, 0);
    check("lhu_be", 32'(cap_be), 32'(4'b1100));

    // Stores: rdata must keep the last load value
    push_exp(0, 32'h0);
    run_access(0, 1, 3'b001, 32'h22, 32'hDEAD_BEEF, 32'h0, 0);
    check("sh_we", 32'(cap_we), 32'd1);
    check("sh_be", 32'(cap_be), 32'(4'b1100));
    check("sh_wdata", cap_wdata, 32'hBEEF_BEEF);
    check("sh_addr", cap_addr, 32'h20);
    push_exp(0, 32'h0);
    run_access(0, 1, 3'b000, 32'h201, 32'h1234_5678, 32'h0, 2);
    check("sb_be", 32'(cap_be), 32'(4'b0010));
    check("sb_wdata", cap_wdata, 32'h7878_7878);
    push_exp(0, 32'h0);
    run_access(1, 1, 3'b010, 32'h300, 32'hCAFE_F00D, 32'h0, 0);
    check("sw_both_we", 32'(cap_we), 32'd1);
    check("sw_be", 32'(cap_be), 32'(4'b1111));
    check("sw_wdata", cap_wdata, 32'hCAFE_F00D);

    // Wait states
    push_exp(1, 32'h1234_5678);
    run_access(1, 0, 3'b010, 32'h40, 32'h0, 32'h1234_5678, 5);
    check("lw_ws_req", 32'(req_cnt), 32'd6);
    check("lw_ws_stall", 32'(stall_cnt), 32'd7);
    check("lw_ws_addr", cap_addr, 32'h40);

    // Random LBU lanes and wait states
    for (int i = 0; i < 4; i++) begin
      lane = $urandom_range(0, 3);
      dly  = $urandom_range(0, 3);
      word = $urandom;
      push_exp(1, (word >> (8 * lane)) & 32'hFF);
      run_access(1, 0, 3'b100, 32'h500 + 32'(lane), 32'h0, word, dly);
      check("rnd_be", 32'(cap_be), 32'(4'b0001 << lane));
      check("rnd_req", 32'(req_cnt), 32'(dly + 1));
    end

    // Faults
    run_fault("f_lw_mis", 1, 0, 3'b010, 32'h41);
    run_fault("f_lh_mis", 1, 0, 3'b001, 32'h03);
    run_fault("f_mask011", 1, 0, 3'b011, 32'h00);
    run_fault("f_sbu", 0, 1, 3'b100, 32'h00);

    // Timeout on the short-budget instance, then a late ack in IDLE
    treq = 0; terr = 0; tstall = 0;
    mem_rd_t = 1'b1; mask = 3'b010; addr = 32'h80;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus_req_t) treq++;
      if (lsu_err_t) begin
        terr++;
        check("to_err_in_req", 32'(bus_req_t), 32'd1);
      end
      if (stall_t) tstall++;
      if (i == 6) ack_t = 1'b1;
      @(posedge clk); #1;
      ack_t = 1'b0;
      if (i == 4) mem_rd_t = 1'b0;
    end
    check("to_req", 32'(treq), 32'd4);
    check("to_err", 32'(terr), 32'd1);
    check("to_stall", 32'(tstall), 32'd5);
    check("to_rdata", rdata_t, 32'h0);
    check("to_addr", bus_addr_t, 32'h80);

    // Reset during REQ with a late ack
    mem_rd = 1'b1; mask = 3'b010; addr = 32'h44; bus_rdata = 32'hAAAA_5555;
    @(posedge clk); #1;
    @(negedge clk);
    check("rq_req", 32'(bus_req), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1; mem_rd = 1'b0;
    @(negedge clk);
    bus_ack = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rr_req", 32'(bus_req), 32'd0);
    check("rr_stall", 32'(stall), 32'd0);
    check("rr_rdata", rdata, 32'h0);
    check("rr_addr", bus_addr, 32'h0);
    check("rr_be", 32'(bus_be), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; bus_ack = 1'b0; model_rdata = 32'h0;
    @(negedge clk);
    check("rr_no_reissue", 32'(bus_req), 32'd0);
    @(posedge clk); #1;
    push_exp(1, 32'h0BAD_F00D);
    run_access(1, 0, 3'b010, 32'h48, 32'h0, 32'h0BAD_F00D, 1);
    check("post_rst_addr", cap_addr, 32'h48);
    check("post_rst_stall", 32'(stall_cnt), 32'd3);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store sequencer between the core's decode/execute stage and a handshaked data-memory bus.
- Takes mem_rd, mem_wr and mask (funct3) from the main control decoder, the effective address from the ALU, and store data from rs2.
- Issues one bus transaction per access, stalls the core until the transaction completes, and returns aligned, sign/zero-extended load data for the writeback mux.
- Detects misaligned accesses, illegal masks and bus timeouts.

Parameters:
- AW, 32, address width.
- TIMEOUT, 255, maximum REQ cycles to wait for bus_ack before aborting; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_rd  in  1  load request from main control.
- mem_wr  in  1  store request from main control.
- mask  in  3  funct3: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- addr  in  AW  effective byte address.
- wdata  in  32  store data (rs2).
- stall  out  1  freeze PC and pipeline registers.
- rdata  out  32  extended load result.
- lsu_err  out  1  one-cycle error pulse.
- bus_req  out  1  transaction request.
- bus_we  out  1  1 = write.
- bus_addr  out  AW  word-aligned address, addr[1:0] forced to 00.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-replicated store data.
- bus_ack  in  1  transaction complete.
- bus_rdata  in  32  raw read word, valid when bus_ack=1.

Behaviour:
- Reset values:
  - state = IDLE.
  - bus_req, bus_we, lsu_err, stall = 0.
  - bus_addr, bus_be, bus_wdata, rdata = 0.
  - timeout counter = 0.
- Access definition: access = mem_rd | mem_wr. If both are high, the access is treated as a store.
- Fault check, evaluated in IDLE:
  - H access with addr[0]=1 → fault.
  - W access with addr[1:0]≠00 → fault.
  - mask ∈ {011, 110, 111} → fault.
  - Store with mask[2]=1 → fault.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - access and no fault: register bus_addr/bus_we/bus_be/bus_wdata, the load-extract controls (addr[1:0], mask), and clear the counter. Next state REQ.
  - access and fault: lsu_err=1 for one cycle. No bus activity, no stall, rdata unchanged. Stay in IDLE.
- REQ:
  - bus_req=1 and all bus outputs are held stable until bus_ack.
  - On bus_ack: for a load, capture the extracted data into rdata. Next state DONE.
  - If TIMEOUT≠0 and the counter reaches TIMEOUT-1 without bus_ack: drop bus_req, pulse lsu_err, leave rdata unchanged. Next state DONE.
- DONE:
  - stall=0 and bus_req=0 for exactly one cycle so the instruction retires.
  - Always returns to IDLE, which prevents re-issuing the same instruction.
- stall is combinational: (IDLE & access & no fault) | REQ.
- Latency: with bus_ack in the first REQ cycle, the core sees 2 stall cycles. rdata is valid in the DONE cycle and holds until the next load completes.
- Byte enables and store data:
  - SB: bus_be = 0001 << addr[1:0]; bus_wdata = {4{wdata[7:0]}}.
  - SH: bus_be = 0011 << {addr[1],0}; bus_wdata = {2{wdata[15:0]}}.
  - SW: bus_be = 1111; bus_wdata = wdata.
  - Loads drive the same bus_be pattern as the equivalent store width.
- Load extract:
  - Shift bus_rdata right by 8*addr[1:0].
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
  - LW passes the word unchanged.
- Ignored inputs: bus_ack outside REQ is ignored; mem_rd/mem_wr are sampled only in IDLE.
- Reset mid-transaction: the FSM returns to IDLE on that edge, bus_req drops, and any late bus_ack is ignored.

Test Plan:
1. Load:
   - Stimulus: LB at addr 0x103, bus_rdata=0x80FF_1234, ack in the 1st REQ cycle.
   - Response: bus_addr=0x100, bus_be=1000, stall high for 2 cycles, rdata=0xFFFF_FF80. Repeat with LBU → rdata=0x0000_0080.
2. Store:
   - Stimulus: SH at addr 0x22, wdata=0xDEAD_BEEF.
   - Response: bus_we=1, bus_be=1100, bus_wdata=0xBEEF_BEEF, bus_addr=0x20. rdata unchanged.
3. Wait states:
   - Stimulus: LW at 0x40, ack delayed 5 cycles, bus_rdata=0x1234_5678.
   - Response: bus_req high 6 cycles with stable address, stall high 7 cycles, rdata=0x1234_5678 in DONE.
4. Faults:
   - Stimulus: LW at 0x41; LH at 0x03; mask=011.
   - Response: each gives a single lsu_err pulse, stall=0, bus_req never asserted, state stays IDLE.
5. Timeout:
   - Stimulus: TIMEOUT=4, no ack.
   - Response: bus_req high exactly 4 cycles, then lsu_err pulse, DONE, IDLE. A late ack is ignored.
6. Reset:
   - Stimulus: rst asserted during REQ.
   - Response: next cycle bus_req=0, stall=0, state IDLE, all outputs at reset values. A subsequent LW completes normally.
